// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared system-bus encodings, burst geometry and responder state type
package sysbus_pkg;
  localparam logic SYSBUS_WRITE = 1'b1;
  localparam logic SYSBUS_READ = 1'b0;
  localparam int SYSBUS_BEATS = 8;
  typedef enum logic [2:0] {IDLE, ADDRACK, WRDATA, WRACK, RDWAIT, RDRESP} resp_state_e;
  function automatic int wflag_bit(input int tag_width);
    return tag_width - 1;
  endfunction
endpackage

// File: rtl/sysbus_mem_array.sv
// sysbus_mem_array: line x beat word storage, synchronous write, combinational read, no reset
module sysbus_mem_array #(
  parameter int WIDTH = 64,
  parameter int LINES = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(LINES)+2:0]      waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [$clog2(LINES)+2:0]      raddr,
  output logic [WIDTH-1:0]              rdata
);
  logic [WIDTH-1:0] mem [LINES*8];
  // commit one write beat per cycle; contents survive reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: line-burst memory endpoint for the system bus; SYSBUS_MEM_CRITWORD_EN enables critical-word-first reads
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int MEM_LINES = 256,
  parameter int READ_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
  localparam int LW = $clog2(MEM_LINES);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY + 1) : 1;
  localparam int WB = wflag_bit(BUS_TAG_WIDTH);
  resp_state_e state, state_nx;
  logic [LW-1:0] line;
  logic [BUS_TAG_WIDTH-1:0] tag;
  logic [2:0] beat, first, crit, start;
  logic [CW-1:0] lat;
  logic [BUS_DATA_WIDTH-1:0] rdata;
  logic we, is_wr, last_rd;
`ifdef SYSBUS_MEM_CRITWORD_EN
  assign crit = bus_req[5:3];
`else
  assign crit = 3'd0;
`endif
  assign start = bus_reqtag[WB] == SYSBUS_WRITE ? 3'd0 : crit;
  assign is_wr = tag[WB] == SYSBUS_WRITE;
  assign last_rd = beat + 3'd1 == first;
  sysbus_mem_array #(.WIDTH(BUS_DATA_WIDTH), .LINES(MEM_LINES)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr ({line, beat}),
    .wdata (bus_req),
    .raddr ({line, beat}),
    .rdata (rdata)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // request latch, beat and latency counters; a read burst ends when beat wraps back to its first beat
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      line <= '0;
      tag <= '0;
      beat <= '0;
      first <= '0;
      lat <= '0;
    end else begin
      case (state)
        IDLE: if (bus_reqcyc) begin
          line <= bus_req[6 +: LW];
          tag <= bus_reqtag;
          beat <= start;
          first <= start;
        end
        ADDRACK: lat <= CW'(READ_LATENCY);
        WRACK: beat <= beat + 3'd1;
        RDWAIT: lat <= lat - CW'(1);
        RDRESP: if (bus_respack) beat <= beat + 3'd1;
        default: ;
      endcase
    end
  // next state, acks, write strobe and response valid
  always_comb begin
    state_nx = state;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    we = 1'b0;
    case (state)
      IDLE: if (bus_reqcyc) state_nx = ADDRACK;
      ADDRACK: begin
        bus_reqack = 1'b1;
        state_nx = is_wr ? WRDATA : (READ_LATENCY == 0 ? RDRESP : RDWAIT);
      end
      WRDATA: if (bus_reqcyc) begin
        we = 1'b1;
        state_nx = WRACK;
      end
      WRACK: begin
        bus_reqack = 1'b1;
        state_nx = beat == 3'(SYSBUS_BEATS - 1) ? IDLE : WRDATA;
      end
      RDWAIT: if (lat <= CW'(1)) state_nx = RDRESP;
      RDRESP: begin
        bus_respcyc = 1'b1;
        if (bus_respack && last_rd) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus_resp = bus_respcyc ? rdata : '0;
  assign bus_resptag = bus_respcyc ? tag : '0;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: randomized scoreboard bench for the system-bus memory responder
module tb_sysbus_mem_responder;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int ML = 256;
  localparam int RL = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bus_reqcyc = 1'b0;
  logic bus_reqack;
  logic [DW-1:0] bus_req = '0;
  logic [TW-1:0] bus_reqtag = '0;
  logic bus_respcyc;
  logic bus_respack = 1'b0;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int ack_cnt = 0;
  logic [TW+DW-1:0] exp_q [$];
  logic [DW-1:0] mdl [ML*8];
  bit written [ML];
  logic [TW+DW-1:0] held;
  bit held_valid = 0;

  sysbus_mem_responder #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_LINES(ML), .READ_LATENCY(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: pops the scoreboard on every accepted beat, checks stalled beats hold still
  always @(negedge clk) begin
    if (!reset) held_valid = 0;
    else begin
      if (bus_reqack) ack_cnt++;
      if (bus_respcyc) begin
        if (held_valid) chk("stall_stable", {bus_resptag, bus_resp}, held);
        if (bus_respack) begin
          if (exp_q.size() == 0) chk("unexpected_beat", {bus_resptag, bus_resp}, 'x);
          else chk("resp_beat", {bus_resptag, bus_resp}, exp_q.pop_front());
          held_valid = 0;
        end else begin
          held = {bus_resptag, bus_resp};
          held_valid = 1;
        end
      end else begin
        chk("resp_idle_zero", {bus_resptag, bus_resp}, 0);
        held_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [DW-1:0] a, input logic [TW-1:0] t, output int c);
    bus_reqcyc = 1'b1;
    bus_req = a;
    bus_reqtag = t;
    c = cyc;
    step();
    bus_reqcyc = 1'b0;
    bus_req = '0;
    bus_reqtag = '0;
    chk("addr_ack", bus_reqack, 1);
  endtask

  task automatic do_write(input logic [DW-1:0] a, input logic [11:0] t, input int gap, input logic [DW-1:0] d [8]);
    int c, line, a0;
    line = int'(a[6 +: 8]);
    a0 = ack_cnt;
    addr_phase(a, {1'b1, t}, c);
    for (int b = 0; b < 8; b++) begin
      step();
      for (int g = 0; g < gap; g++) begin
        chk("wr_gap_noack", bus_reqack, 0);
        bus_req = DW'($urandom);
        step();
      end
      chk("wr_wait_noack", bus_reqack, 0);
      bus_reqcyc = 1'b1;
      bus_req = d[b];
      step();
      bus_reqcyc = 1'b0;
      bus_req = '0;
      chk("wr_beat_ack", bus_reqack, 1);
      mdl[line*8 + b] = d[b];
    end
    written[line] = 1;
    step();
    chk("wr_ack_total", ack_cnt - a0, 9);
    chk("wr_end_noack", bus_reqack, 0);
  endtask

  task automatic do_read(input logic [DW-1:0] a, input logic [11:0] t, input int stall_beat, input int stall_n, input int nacc);
    int c, line, st, got, stalls, to;
    bit seen;
    line = int'(a[6 +: 8]);
`ifdef SYSBUS_MEM_CRITWORD_EN
    st = int'(a[5:3]);
`else
    st = 0;
`endif
    for (int i = 0; i < nacc; i++) exp_q.push_back({1'b0, t, mdl[line*8 + (st + i) % 8]});
    addr_phase(a, {1'b0, t}, c);
    step();
    chk("ack_one_cycle", bus_reqack, 0);
    got = 0;
    stalls = 0;
    to = 0;
    seen = 0;
    while (got < nacc && to < 100) begin
      if (bus_respcyc) begin
        if (!seen) chk("first_resp_cycle", cyc, c + 2 + RL);
        seen = 1;
        if (got == stall_beat && stalls < stall_n) begin
          bus_respack = 1'b0;
          stalls++;
        end else begin
          bus_respack = 1'b1;
          got++;
        end
      end else bus_respack = 1'($urandom_range(0, 1));
      step();
      to++;
    end
    bus_respack = 1'b0;
    chk("read_beats_done", got, nacc);
    if (nacc == 8) chk("read_end_idle", bus_respcyc, 0);
  endtask

  initial begin
    logic [DW-1:0] d [8];
    logic [DW-1:0] a;
    int ln;
    #1;
    chk("rst_reqack", bus_reqack, 0);
    chk("rst_respcyc", bus_respcyc, 0);
    chk("rst_resp", {bus_resptag, bus_resp}, 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) d[i] = DW'((i + 1) * 'h11);
    do_write(64'h1000, 12'h0a5, 0, d);
    do_read(64'h1000, 12'h123, -1, 0, 8);
    do_read(64'h1000, 12'h456, 2, 3, 8);
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    do_write(64'h2000, 12'h777, 2, d);
    do_read(64'h2000, 12'h0f0, int'($urandom_range(0, 7)), 2, 8);
    do_read(64'h1000 + ML * 64, 12'h321, -1, 0, 8);
    do_read(64'h1028, 12'h028, -1, 0, 8);
    do_read(64'h1000, 12'h099, -1, 0, 4);
    chk("beat4_pending", bus_respcyc, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_respcyc", bus_respcyc, 0);
    chk("rst_mid_resp", {bus_resptag, bus_resp}, 0);
    chk("rst_mid_reqack", bus_reqack, 0);
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_queue_empty", exp_q.size(), 0);
    do_read(64'h2000, 12'h555, -1, 0, 8);
    for (int k = 0; k < 6; k++) begin
      ln = int'($urandom_range(0, ML - 1));
      a = {$urandom, $urandom};
      a[6 +: 8] = 8'(ln);
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      do_write(a, 12'($urandom), int'($urandom_range(0, 2)), d);
      do
        ln = int'($urandom_range(0, ML - 1));
      while (!written[ln]);
      a = {$urandom, $urandom};
      a[6 +: 8] = 8'(ln);
      do_read(a, 12'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8);
    end
    repeat (2) step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
